imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the PC/branch logic.
- Accepts one word-aligned fetch address per request handshake and inserts a configurable number of wait cycles.
- Returns the instruction word on a valid/ready response channel.
- Supports a pipeline flush that cancels an in-flight fetch when a branch or jump redirects the PC; a side write port loads program contents.

Parameters:
- ADDR_SIZE, 32, width of fetch and write addresses (matches ADDR_SIZE define).
- DATA_SIZE, 32, instruction word width.
- DEPTH_WORDS, 1024, number of words in storage; word index = addr[ADDR_SIZE-1:2].
- LATENCY, 2, wait cycles between request acceptance and response capture; legal range 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept request this cycle.
- req_addr  in  ADDR_SIZE  fetch byte address.
- flush  in  1  cancel any in-flight fetch (branch taken / jump).
- rsp_valid  out  1  response word present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_SIZE  fetched instruction.
- rsp_err  out  1  misaligned or out-of-range fetch.
- wr_en  in  1  program-load word write.
- wr_addr  in  ADDR_SIZE  byte address of word write (bits [1:0] ignored).
- wr_data  in  DATA_SIZE  word to write.

Behaviour:
- States:
  - IDLE: no fetch held.
  - WAIT: counting wait cycles.
  - RESP: response held.
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE; wait counter = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0; latched address = 0.
  - Memory contents are not cleared.
  - A reset asserted mid-WAIT or mid-RESP drops the fetch with no response.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready && !flush). It is combinational and never depends on req_valid.
- Accept:
  - Occurs on the edge where req_valid && req_ready; req_addr is latched.
  - If LATENCY>0, go to WAIT with counter = LATENCY-1.
  - If LATENCY==0, capture immediately and go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==0: capture, go to RESP, assert rsp_valid.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
- Capture:
  - err = (latched addr[1:0]!=0) || (word index >= DEPTH_WORDS).
  - If err, rsp_data = 32'h00000013 (NOP) and rsp_err = 1.
  - Otherwise rsp_data = mem[index] and rsp_err = 0.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_ready.
  - On handshake with a simultaneous accept: go to WAIT (or back to RESP with new data if LATENCY==0), giving back-to-back throughput of one fetch per LATENCY+1 cycles.
  - On handshake without an accept: go to IDLE and drop rsp_valid.
- Flush:
  - In WAIT: go to IDLE next edge; no response is produced.
  - In RESP: rsp_valid drops next edge, state goes to IDLE, and no accept happens that cycle. A response with rsp_ready=1 on the flush cycle counts as transferred.
  - In IDLE: no effect; a simultaneous request (the redirected PC) is accepted normally.
- Write port:
  - The word write takes effect at the edge and is independent of the fetch FSM.
  - Writes with out-of-range index are ignored.
  - A write to the captured word on the capture edge: the response returns old data (read-before-write).
- Reset has priority over flush; flush has priority over all other transitions.

Test Plan:
- Load mem[0]=32'h00500093, mem[1]=32'h00100113 via write port; LATENCY=2; request 0x0 accepted at cycle 0 with rsp_ready=1 -> rsp_valid at cycle 3, rsp_data=32'h00500093, rsp_err=0.
- Back-to-back: hold req_valid with addr 0x0 then 0x4, rsp_ready=1 -> second accept coincides with the first response handshake; responses 32'h00500093 then 32'h00100113 spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable and req_ready=0; release -> single transfer, then IDLE.
- Errors: request 0x2 -> rsp_err=1, rsp_data=32'h00000013; request 0x1000 (index 1024) -> rsp_err=1, rsp_data=32'h00000013.
- Flush: accept 0x4, assert flush one cycle later (in WAIT) -> no rsp_valid ever; flush with req_valid addr 0x0 in IDLE -> accepted, response 32'h00500093.
- Reset mid-WAIT: synchronous reset pulse -> next edge state IDLE, rsp_valid=0, rsp_data=0; a subsequent fetch of 0x0 still returns 32'h00500093 (memory retained).

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch request/response, flush and program-load signals between PC logic and imem_responder.
// Master drives requests, flush, response ready and writes; slave returns ready, response word and error.
interface imem_responder_if #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_SIZE-1:0] req_addr;
    logic                 flush;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_SIZE-1:0] rsp_data;
    logic                 rsp_err;
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [DATA_SIZE-1:0] wr_data;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, response LATENCY+1 cycles after accept.
// Response held until rsp_ready; a new request is taken only from IDLE or on the response handshake.
module imem_responder #(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    imem_responder_if.slave bus
);
    localparam int                   IDXW      = ADDR_SIZE - 2;
    localparam int                   MW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDXW-1:0]      DEPTH_LIM = IDXW'(DEPTH_WORDS);
    localparam logic [DATA_SIZE-1:0] NOP       = DATA_SIZE'(32'h0000_0013);
    localparam logic [3:0]           LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [ADDR_SIZE-1:0] addr_q, addr_nxt, cap_addr;
    logic [DATA_SIZE-1:0] data_q;
    logic                 err_q;
    logic                 req_rdy, accept, capture, cap_err;
    logic [IDXW-1:0]      cap_idx, wr_idx;
    logic                 unused_wr_lsb;

    logic [DATA_SIZE-1:0] mem [DEPTH_WORDS];

    assign req_rdy       = (state == IDLE) || (state == RESP && bus.rsp_ready && !bus.flush);
    assign accept        = bus.req_valid && req_rdy;
    assign cap_idx       = cap_addr[ADDR_SIZE-1:2];
    assign cap_err       = (cap_addr[1:0] != 2'b00) || (cap_idx >= DEPTH_LIM);
    assign wr_idx        = bus.wr_addr[ADDR_SIZE-1:2];
    assign unused_wr_lsb = ^bus.wr_addr[1:0];

    assign bus.req_ready = req_rdy;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        capture   = 1'b0;
        cap_addr  = addr_q;
        case (state)
            IDLE, RESP: begin
                if (state == RESP && bus.flush) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    addr_nxt = bus.req_addr;
                    // Zero latency captures straight from the request bus on the accept edge.
                    if (LATENCY == 0) begin
                        capture   = 1'b1;
                        cap_addr  = bus.req_addr;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = LAT_M1;
                        state_nxt = WAIT;
                    end
                end else if (state == RESP && bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            if (capture) begin
                err_q  <= cap_err;
                data_q <= cap_err ? NOP : mem[cap_idx[MW-1:0]];
            end
        end
    end

    // Non-blocking write: a capture on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (wr_idx < DEPTH_LIM)) begin
            mem[wr_idx[MW-1:0]] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus a random request/backpressure stream
// scored against a word-array model and an in-order queue of accepted fetches.
module tb_imem_responder;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] a;
        int          c;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] mdl [DEPTH];

    imem_responder_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    imem_responder #(
        .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (int'(a[31:2]) >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (exp_err(a)) return NOP;
        return mdl[a[11:2]];
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (int'(a[31:2]) < DEPTH) mdl[a[11:2]] = d;
    endtask

    // Called right after the accept edge; lat counts that edge as cycle 1, -1 on timeout.
    task automatic wait_vld(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!bus.rsp_valid) lat = -1;
    endtask

    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        wait_vld(lat);
        d = bus.rsp_data;
        e = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
        n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] d; logic e; int lat;
        do_write(32'h0, 32'h0050_0093);
        do_write(32'h4, 32'h0010_0113);
        fetch(32'h0, d, e, lat);
        n_tests++; if (lat != LAT + 1) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, LAT + 1); end
        n_tests++; if (d !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_data got %h want 00500093", d); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", e); end
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.rsp_ready = 1'b1;
        step();
        bus.req_addr = 32'h4;
        wait_vld(n);
        n_tests++; if (n != LAT + 1) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", n, LAT + 1); end
        n_tests++; if (bus.rsp_data !== mdl[0]) begin n_fail++; $display("FAIL b2b_first_data got %h want %h", bus.rsp_data, mdl[0]); end
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_handshake got %b want 1", bus.req_ready); end
        step();
        bus.req_valid = 1'b0;
        wait_vld(n);
        n_tests++; if (n != LAT + 1) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", n, LAT + 1); end
        n_tests++; if (bus.rsp_data !== mdl[1]) begin n_fail++; $display("FAIL b2b_second_data got %h want %h", bus.rsp_data, mdl[1]); end
        step();
        bus.rsp_ready = 1'b0;
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        int n;
        bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        wait_vld(n);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== mdl[1] || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got vld=%b data=%h rdy=%b want 1/%h/0", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, mdl[1]);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got vld=%b want 0", bus.rsp_valid); end
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int lat;
        fetch(32'h2, d, e, lat);
        n_tests++; if (d !== NOP || e !== 1'b1 || lat != LAT + 1) begin n_fail++; $display("FAIL err_misaligned got %h/%b/%0d want %h/1/%0d", d, e, lat, NOP, LAT + 1); end
        fetch(32'h1000, d, e, lat);
        n_tests++; if (d !== NOP || e !== 1'b1) begin n_fail++; $display("FAIL err_range got %h/%b want %h/1", d, e, NOP); end
        do_write(32'hFFC, 32'h0BAD_F00D);
        fetch(32'hFFC, d, e, lat);
        n_tests++; if (d !== exp_data(32'hFFC) || e !== 1'b0) begin n_fail++; $display("FAIL last_word got %h/%b want %h/0", d, e, exp_data(32'hFFC)); end
        do_write(32'h1000, 32'hDEAD_BEEF);
        fetch(32'h0, d, e, lat);
        n_tests++; if (d !== exp_data(32'h0)) begin n_fail++; $display("FAIL oob_write_ignored got %h want %h", d, exp_data(32'h0)); end
    endtask

    task automatic test_flush();
        logic seen; int n;
        bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        seen = 1'b0;
        repeat (8) begin seen |= bus.rsp_valid; step(); end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_wait_response got vld=%b want 0", seen); end
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0;
        #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready got %b want 1", bus.req_ready); end
        step();
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        wait_vld(n);
        n_tests++; if (n != LAT + 1 || bus.rsp_data !== mdl[0]) begin n_fail++; $display("FAIL flush_idle_accept got lat=%0d data=%h want %0d/%h", n, bus.rsp_data, LAT + 1, mdl[0]); end
        step();
        // Flush while a response waits for a stalled consumer.
        bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        wait_vld(n);
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0;
        #1;
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_resp_ready got %b want 0", bus.req_ready); end
        step();
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin seen |= bus.rsp_valid; step(); end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_resp_drop got vld=%b want 0", seen); end
    endtask

    task automatic test_read_before_write();
        logic [31:0] d; logic e; int lat;
        do_write(32'h8, 32'h0020_0193);
        bus.req_valid = 1'b1; bus.req_addr = 32'h8; bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        repeat (LAT - 1) step();
        bus.wr_en = 1'b1; bus.wr_addr = 32'h8; bus.wr_data = 32'h00A0_0193;
        step();
        bus.wr_en = 1'b0;
        n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0020_0193) begin n_fail++; $display("FAIL rbw_old_data got vld=%b data=%h want 1/00200193", bus.rsp_valid, bus.rsp_data); end
        mdl[2] = 32'h00A0_0193;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        fetch(32'h8, d, e, lat);
        n_tests++; if (d !== mdl[2]) begin n_fail++; $display("FAIL rbw_new_data got %h want %h", d, mdl[2]); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d; logic e; int lat; logic seen;
        bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_wait_outputs got %b/%h/%b want 0/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready got %b want 1", bus.req_ready); end
        seen = 1'b0;
        repeat (6) begin seen |= bus.rsp_valid; step(); end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_wait_dropped got vld=%b want 0", seen); end
        fetch(32'h0, d, e, lat);
        n_tests++; if (d !== 32'h0050_0093 || e !== 1'b0) begin n_fail++; $display("FAIL rst_mem_retained got %h/%b want 00500093/0", d, e); end
    endtask

    task automatic test_random_stream();
        ent_t        q[$];
        logic        pv = 1'b0, phs = 1'b0, pe = 1'b0, hs, exp_rdy;
        logic [31:0] pd = '0, a;
        int          r;
        for (int w = 2; w < 64; w++) do_write(32'(w) << 2, $urandom);
        for (int i = 0; i < 420; i++) begin
            r = int'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 63)) << 2;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = a + 32'h1000;
            bus.req_addr  = a;
            bus.req_valid = (i < 400) && ($urandom_range(0, 3) != 0);
            bus.rsp_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || (bus.rsp_valid && bus.rsp_ready);
            n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_req_ready cyc %0d got %b want %b", cyc, bus.req_ready, exp_rdy); end
            if (pv && !phs) begin
                n_tests++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== pd || bus.rsp_err !== pe) begin
                    n_fail++; $display("FAIL rnd_hold cyc %0d got %b/%h/%b want 1/%h/%b", cyc, bus.rsp_valid, bus.rsp_data, bus.rsp_err, pd, pe);
                end
            end
            if (bus.rsp_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious_rsp cyc %0d got data=%h want no response", cyc, bus.rsp_data);
                end else if (bus.rsp_data !== exp_data(q[0].a) || bus.rsp_err !== exp_err(q[0].a)) begin
                    n_fail++; $display("FAIL rnd_data addr %h got %h/%b want %h/%b", q[0].a, bus.rsp_data, bus.rsp_err, exp_data(q[0].a), exp_err(q[0].a));
                end
                if (q.size() != 0 && (!pv || phs)) begin
                    n_tests++; if (cyc - q[0].c != LAT + 1) begin n_fail++; $display("FAIL rnd_latency addr %h got %0d want %0d", q[0].a, cyc - q[0].c, LAT + 1); end
                end
            end
            hs = bus.rsp_valid && bus.rsp_ready;
            if (hs && q.size() != 0) void'(q.pop_front());
            if (bus.req_valid && bus.req_ready) q.push_back('{a: a, c: cyc});
            pv = bus.rsp_valid; phs = hs; pd = bus.rsp_data; pe = bus.rsp_err;
            step();
        end
        n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d outstanding want 0", q.size()); end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.rsp_ready = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_flush();
        test_read_before_write();
        test_reset_mid_wait();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time %0t want completion", $time);
        $fatal(1, "timeout");
    end
endmodule
